// File: rtl/vc_sram_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_sram_adapter_pkg
// Description : Shared encodings and the response entry type for the SRAM
//               request/response adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_sram_adapter_pkg;

    // req_type / rsp_type encoding
    localparam logic c_req_read  = 1'b0;
    localparam logic c_req_write = 1'b1;

    // Data width of the default response entry; the adapter overrides the
    // entry type with one sized to its own word width.
    localparam int c_rsp_data_nbits = 32;

    typedef struct packed {
        logic                        rtype;
        logic [c_rsp_data_nbits-1:0] data;
    } rsp_entry_t;

endpackage
`default_nettype wire

// File: rtl/vc_sram_adapter_rsp_queue.sv
`default_nettype none
// ============================================================================
// Module      : vc_sram_adapter_rsp_queue
// Description : Two-entry FIFO holding responses the consumer has not yet
//               accepted. Head is presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_sram_adapter_rsp_queue
    import vc_sram_adapter_pkg::*;
#(
    parameter type t_entry = rsp_entry_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enq_val,
    input  t_entry     enq_entry,
    input  logic       deq_rdy,
    output logic [1:0] count,
    output t_entry     head
);

    t_entry     r_entries [2];
    logic       r_head_ptr;
    logic       r_tail_ptr;
    logic [1:0] r_count;
    logic       w_enq;
    logic       w_deq;

    assign w_deq = deq_rdy && (r_count != 2'd0);
    // A full queue only accepts a new entry in a cycle that frees a slot.
    assign w_enq = enq_val && ((r_count != 2'd2) || w_deq);

    // Entry storage needs no reset: it is only observed when count says valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_entries[r_tail_ptr] <= enq_entry;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head_ptr <= 1'b0;
            r_tail_ptr <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            if (w_enq) begin
                r_tail_ptr <= ~r_tail_ptr;
            end
            if (w_deq) begin
                r_head_ptr <= ~r_head_ptr;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 2'd1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign count = r_count;
    assign head  = r_entries[r_head_ptr];

endmodule
`default_nettype wire

// File: rtl/vc_sram_req_rsp_adapter.sv
`default_nettype none
// ============================================================================
// Module      : vc_sram_req_rsp_adapter
// Description : Bridges a val/rdy request/response interface onto a
//               synchronous 1-cycle-latency SRAM. Read data is bypassed to
//               the response port when nothing is queued, otherwise it is
//               queued behind older responses. At most two responses are
//               ever outstanding (queued plus in flight).
//               Build option VC_SRAM_ADAPTER_WRITE_ACK_EN: writes also return
//               a response (type 1, data 0), ordered with reads.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_sram_req_rsp_adapter
    import vc_sram_adapter_pkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_data_nbytes = (p_data_nbits + 7) / 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_type,
    input  logic [c_addr_nbits-1:0]  req_addr,
    input  logic [p_data_nbits-1:0]  req_data,
    input  logic [c_data_nbytes-1:0] req_byte_en,

    output logic                     rsp_val,
    input  logic                     rsp_rdy,
    output logic                     rsp_type,
    output logic [p_data_nbits-1:0]  rsp_data,

    output logic                     sram_read_en,
    output logic [c_addr_nbits-1:0]  sram_read_addr,
    output logic                     sram_write_en,
    output logic [c_data_nbytes-1:0] sram_write_byte_en,
    output logic [c_addr_nbits-1:0]  sram_write_addr,
    output logic [p_data_nbits-1:0]  sram_write_data,
    input  logic [p_data_nbits-1:0]  sram_read_data
);

    typedef struct packed {
        logic                    rtype;
        logic [p_data_nbits-1:0] data;
    } t_rsp_entry;

    logic       r_active;
    logic       r_inflight;
    logic       r_inflight_type;
    logic       w_xfer;
    logic       w_is_write;
    logic       w_due_set;
    logic       w_queue_empty;
    logic       w_enq;
    logic [1:0] w_count;
    logic [1:0] w_occupancy;
    t_rsp_entry w_due;
    t_rsp_entry w_head;

    // Ready depends only on registered state, never on rsp_rdy. r_active
    // holds ready low while reset is asserted and rises on the first edge after.
    assign w_occupancy = w_count + {1'b0, r_inflight};
    assign req_rdy     = r_active && (w_occupancy < 2'd2);
    assign w_xfer      = req_val && req_rdy;
    assign w_is_write  = (req_type == c_req_write);

    assign sram_read_en       = w_xfer && !w_is_write;
    assign sram_read_addr     = req_addr;
    assign sram_write_en      = w_xfer && w_is_write;
    assign sram_write_byte_en = req_byte_en;
    assign sram_write_addr    = req_addr;
    assign sram_write_data    = req_data;

`ifdef VC_SRAM_ADAPTER_WRITE_ACK_EN
    assign w_due_set = w_xfer;
`else
    assign w_due_set = w_xfer && !w_is_write;
`endif

    // Track the response that becomes due on the next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_active        <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_type <= c_req_read;
        end else begin
            r_active        <= 1'b1;
            r_inflight      <= w_due_set;
            r_inflight_type <= w_due_set && w_is_write;
        end
    end

    // Due response: SRAM read data is only valid this cycle; write acks carry zero.
    always_comb begin
        w_due.rtype = r_inflight_type;
        w_due.data  = (r_inflight_type == c_req_write) ? '0 : sram_read_data;
    end

    assign w_queue_empty = (w_count == 2'd0);
    assign rsp_val       = r_inflight || !w_queue_empty;
    assign rsp_type      = w_queue_empty ? w_due.rtype : w_head.rtype;
    assign rsp_data      = w_queue_empty ? w_due.data  : w_head.data;
    // Queue the due response unless it was bypassed and taken this cycle.
    assign w_enq         = r_inflight && !(w_queue_empty && rsp_rdy);

    vc_sram_adapter_rsp_queue #(
        .t_entry   (t_rsp_entry)
    ) u_rsp_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_val   (w_enq),
        .enq_entry (w_due),
        .deq_rdy   (rsp_rdy),
        .count     (w_count),
        .head      (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_vc_sram_req_rsp_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_sram_req_rsp_adapter
// Description : Self-checking bench for vc_sram_req_rsp_adapter with a
//               behavioural SRAM, a vector table, directed corner sequences
//               and a randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_sram_req_rsp_adapter;

    localparam int c_dw = 16;
    localparam int c_ne = 256;
    localparam int c_aw = 8;
    localparam int c_nb = 2;
`ifdef VC_SRAM_ADAPTER_WRITE_ACK_EN
    localparam logic c_ack = 1'b1;
`else
    localparam logic c_ack = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            req_val;
    logic            req_rdy;
    logic            req_type;
    logic [c_aw-1:0] req_addr;
    logic [c_dw-1:0] req_data;
    logic [c_nb-1:0] req_byte_en;
    logic            rsp_val;
    logic            rsp_rdy;
    logic            rsp_type;
    logic [c_dw-1:0] rsp_data;
    logic            sram_read_en;
    logic [c_aw-1:0] sram_read_addr;
    logic            sram_write_en;
    logic [c_nb-1:0] sram_write_byte_en;
    logic [c_aw-1:0] sram_write_addr;
    logic [c_dw-1:0] sram_write_data;
    logic [c_dw-1:0] sram_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_sram_req_rsp_adapter #(
        .p_data_nbits       (c_dw),
        .p_num_entries      (c_ne)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_val            (req_val),
        .req_rdy            (req_rdy),
        .req_type           (req_type),
        .req_addr           (req_addr),
        .req_data           (req_data),
        .req_byte_en        (req_byte_en),
        .rsp_val            (rsp_val),
        .rsp_rdy            (rsp_rdy),
        .rsp_type           (rsp_type),
        .rsp_data           (rsp_data),
        .sram_read_en       (sram_read_en),
        .sram_read_addr     (sram_read_addr),
        .sram_write_en      (sram_write_en),
        .sram_write_byte_en (sram_write_byte_en),
        .sram_write_addr    (sram_write_addr),
        .sram_write_data    (sram_write_data),
        .sram_read_data     (sram_read_data)
    );

    // Behavioural synchronous SRAM: byte-enabled write, registered read.
    logic [c_dw-1:0] sram_mem [c_ne];
    always @(posedge clk) begin
        if (sram_write_en) begin
            for (int b = 0; b < c_nb; b++) begin
                if (sram_write_byte_en[b]) begin
                    sram_mem[sram_write_addr][8*b +: 8] <= sram_write_data[8*b +: 8];
                end
            end
        end
        if (sram_read_en) begin
            sram_read_data <= sram_mem[sram_read_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 later.
    task automatic drive(input logic v, input logic t, input logic [c_aw-1:0] a,
                         input logic [c_dw-1:0] d, input logic [c_nb-1:0] be, input logic rr);
        @(negedge clk);
        req_val     = v;
        req_type    = t;
        req_addr    = a;
        req_data    = d;
        req_byte_en = be;
        rsp_rdy     = rr;
        #1;
    endtask

    task automatic idle(input logic rr);
        drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, rr);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            v;
        logic            t;
        logic [c_aw-1:0] a;
        logic [c_dw-1:0] d;
        logic [c_nb-1:0] be;
        logic            e_val;
        logic [c_dw-1:0] e_data;
        logic            e_re;
        logic            e_we;
    } vec_t;

    function automatic vec_t mkvec(input logic v, input logic t, input logic [c_aw-1:0] a,
                                   input logic [c_dw-1:0] d, input logic [c_nb-1:0] be,
                                   input logic e_val, input logic [c_dw-1:0] e_data,
                                   input logic e_re, input logic e_we);
        vec_t r;
        r.v = v; r.t = t; r.a = a; r.d = d; r.be = be;
        r.e_val = e_val; r.e_data = e_data; r.e_re = e_re; r.e_we = e_we;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic            t;
        logic [c_dw-1:0] d;
    } rsp_t;

    rsp_t            exp_q [$];
    logic [c_dw-1:0] ref_mem [c_ne];

    // Outstanding responses = everything transferred but not yet accepted.
    task automatic model_cycle(input logic v, input logic t, input logic [c_aw-1:0] a,
                               input logic [c_dw-1:0] d, input logic [c_nb-1:0] be, input logic rr);
        logic m_rdy;
        logic m_xfer;
        rsp_t e;
        drive(v, t, a, d, be, rr);
        m_rdy  = (exp_q.size() < 2);
        m_xfer = v && m_rdy;
        check("rnd_req_rdy", 32'(req_rdy), 32'(m_rdy));
        check("rnd_rsp_val", 32'(rsp_val), 32'(exp_q.size() != 0));
        check("rnd_read_en", 32'(sram_read_en), 32'(m_xfer && !t));
        check("rnd_write_en", 32'(sram_write_en), 32'(m_xfer && t));
        if (rr && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rnd_rsp_type", 32'(rsp_type), 32'(e.t));
            check("rnd_rsp_data", 32'(rsp_data), 32'(e.d));
        end
        if (m_xfer) begin
            if (t) begin
                for (int b = 0; b < c_nb; b++) begin
                    if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                end
                if (c_ack) exp_q.push_back({1'b1, 16'h0000});
            end else begin
                exp_q.push_back({1'b0, ref_mem[a]});
            end
        end
    endtask

    initial begin : main
        vec_t            vecs [9];
        logic [c_dw-1:0] wvals [5];
        rsp_t            got [$];

        reset = 1'b0;
        req_val = 1'b0; req_type = 1'b0; req_addr = '0; req_data = '0;
        req_byte_en = '0; rsp_rdy = 1'b0;

        // ---- reset state ----
        drive(1'b1, 1'b0, 8'h00, 16'h0000, 2'b11, 1'b1);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_rsp_val", 32'(rsp_val), 32'd0);
        check("rst_read_en", 32'(sram_read_en), 32'd0);
        drive(1'b1, 1'b1, 8'h00, 16'h1234, 2'b11, 1'b1);
        check("rst_write_en", 32'(sram_write_en), 32'd0);
        reset = 1'b1;
        idle(1'b1);
        check("post_rst_req_rdy", 32'(req_rdy), 32'd1);
        check("post_rst_rsp_val", 32'(rsp_val), 32'd0);

        // ---- vector table: basic write/read and partial writes ----
        vecs[0] = mkvec(1, 1, 8'd0, 16'haaaa, 2'b11, 1'b0,  16'h0000, 1'b0, 1'b1);
        vecs[1] = mkvec(1, 0, 8'd0, 16'h0000, 2'b00, c_ack, 16'h0000, 1'b1, 1'b0);
        vecs[2] = mkvec(0, 0, 8'd0, 16'h0000, 2'b00, 1'b1,  16'haaaa, 1'b0, 1'b0);
        vecs[3] = mkvec(1, 1, 8'd0, 16'haaaa, 2'b10, 1'b0,  16'h0000, 1'b0, 1'b1);
        vecs[4] = mkvec(1, 1, 8'd0, 16'hdddd, 2'b01, c_ack, 16'h0000, 1'b0, 1'b1);
        vecs[5] = mkvec(1, 1, 8'd0, 16'h0123, 2'b00, c_ack, 16'h0000, 1'b0, 1'b1);
        vecs[6] = mkvec(1, 0, 8'd0, 16'h0000, 2'b00, c_ack, 16'h0000, 1'b1, 1'b0);
        vecs[7] = mkvec(0, 0, 8'd0, 16'h0000, 2'b00, 1'b1,  16'haadd, 1'b0, 1'b0);
        vecs[8] = mkvec(0, 0, 8'd0, 16'h0000, 2'b00, 1'b0,  16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].v, vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].be, 1'b1);
            check($sformatf("vec%0d_req_rdy", i), 32'(req_rdy), 32'd1);
            check($sformatf("vec%0d_rsp_val", i), 32'(rsp_val), 32'(vecs[i].e_val));
            check($sformatf("vec%0d_read_en", i), 32'(sram_read_en), 32'(vecs[i].e_re));
            check($sformatf("vec%0d_write_en", i), 32'(sram_write_en), 32'(vecs[i].e_we));
            if (vecs[i].e_val) begin
                check($sformatf("vec%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].e_data));
                check($sformatf("vec%0d_rsp_type", i), 32'(rsp_type), 32'(vecs[i].e_data == 16'h0 && c_ack));
            end
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_wr_byte_en", i), 32'(sram_write_byte_en), 32'(vecs[i].be));
            end
        end

        // ---- back-to-back reads at full throughput ----
        wvals[0] = 16'haaaa; wvals[1] = 16'hbbbb; wvals[2] = 16'hcccc;
        wvals[3] = 16'hdddd; wvals[4] = 16'heeee;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, 8'(k), wvals[k], 2'b11, 1'b1);
            check("b2b_wr_rdy", 32'(req_rdy), 32'd1);
        end
        idle(1'b1);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 8'(k), 16'h0000, 2'b00, 1'b1);
            check("b2b_rd_rdy", 32'(req_rdy), 32'd1);
            if (k > 0) begin
                check("b2b_rsp_val", 32'(rsp_val), 32'd1);
                check("b2b_rsp_data", 32'(rsp_data), 32'(wvals[k-1]));
            end
        end
        idle(1'b1);
        check("b2b_last_val", 32'(rsp_val), 32'd1);
        check("b2b_last_data", 32'(rsp_data), 32'(wvals[4]));

        // ---- backpressure: two outstanding blocks the third read ----
        drive(1'b1, 1'b0, 8'd1, 16'h0, 2'b00, 1'b0);
        check("bp_c0_rdy", 32'(req_rdy), 32'd1);
        drive(1'b1, 1'b0, 8'd2, 16'h0, 2'b00, 1'b0);
        check("bp_c1_rdy", 32'(req_rdy), 32'd1);
        check("bp_c1_data", 32'(rsp_data), 32'h0000bbbb);
        drive(1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 1'b0);
        check("bp_c2_rdy", 32'(req_rdy), 32'd0);
        check("bp_c2_data", 32'(rsp_data), 32'h0000bbbb);
        drive(1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 1'b0);
        check("bp_c3_rdy", 32'(req_rdy), 32'd0);
        check("bp_c3_hold", 32'(rsp_data), 32'h0000bbbb);
        drive(1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 1'b1);
        check("bp_c4_rdy", 32'(req_rdy), 32'd0);
        check("bp_c4_data", 32'(rsp_data), 32'h0000bbbb);
        drive(1'b1, 1'b0, 8'd3, 16'h0, 2'b00, 1'b1);
        check("bp_c5_rdy", 32'(req_rdy), 32'd1);
        check("bp_c5_read_en", 32'(sram_read_en), 32'd1);
        check("bp_c5_data", 32'(rsp_data), 32'h0000cccc);
        idle(1'b1);
        check("bp_c6_val", 32'(rsp_val), 32'd1);
        check("bp_c6_data", 32'(rsp_data), 32'h0000dddd);
        idle(1'b1);
        check("bp_c7_val", 32'(rsp_val), 32'd0);

        // ---- reset with two queued responses ----
        drive(1'b1, 1'b0, 8'd1, 16'h0, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 8'd2, 16'h0, 2'b00, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("mr_pre_val", 32'(rsp_val), 32'd1);
        check("mr_pre_rdy", 32'(req_rdy), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("mr_rsp_val", 32'(rsp_val), 32'd0);
        check("mr_req_rdy", 32'(req_rdy), 32'd0);
        drive(1'b1, 1'b0, 8'd1, 16'h0, 2'b00, 1'b1);
        check("mr_hold_val", 32'(rsp_val), 32'd0);
        check("mr_hold_read_en", 32'(sram_read_en), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("mr_after_rdy", 32'(req_rdy), 32'd1);
            check("mr_after_val", 32'(rsp_val), 32'd0);
        end

        // ---- write then read: response count depends on write acks ----
        drive(1'b1, 1'b1, 8'd30, 16'h5a5a, 2'b11, 1'b1);
        if (rsp_val) got.push_back({rsp_type, rsp_data});
        drive(1'b1, 1'b0, 8'd30, 16'h0000, 2'b00, 1'b1);
        if (rsp_val) got.push_back({rsp_type, rsp_data});
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            if (rsp_val) got.push_back({rsp_type, rsp_data});
        end
        check("wa_num_rsp", 32'(got.size()), c_ack ? 32'd2 : 32'd1);
        if (got.size() != 0) begin
            check("wa_last_type", 32'(got[got.size()-1].t), 32'd0);
            check("wa_last_data", 32'(got[got.size()-1].d), 32'h00005a5a);
            check("wa_first_type", 32'(got[0].t), 32'(c_ack));
        end

        // ---- randomized run against the reference model ----
        for (int k = 16; k < 24; k++) begin
            model_cycle(1'b1, 1'b1, 8'(k), 16'($urandom), 2'b11, 1'b1);
        end
        for (int k = 0; k < 500; k++) begin
            model_cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                        8'($urandom_range(16, 23)), 16'($urandom),
                        2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7));
        end
        for (int k = 0; k < 10; k++) begin
            if (exp_q.size() != 0) model_cycle(1'b0, 1'b0, 8'd16, 16'h0, 2'b00, 1'b1);
        end
        check("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_sram_req_rsp_adapter.md
VC_SRAM_REQ_RSP_ADAPTER -- requirements
Module: vc_sram_req_rsp_adapter

Interface
REQ-001 SHALL have parameter p_data_nbits, default 32, SRAM word width in bits.
REQ-002 SHALL have parameter p_num_entries, default 256, SRAM depth; derived c_addr_nbits = $clog2(p_num_entries) and c_data_nbytes = (p_data_nbits+7)/8.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_val (input, 1) and req_rdy (output, 1), the request handshake.
REQ-006 SHALL have ports req_type (input, 1; 0 = read, 1 = write), req_addr (input, c_addr_nbits), req_data (input, p_data_nbits) and req_byte_en (input, c_data_nbytes).
REQ-007 SHALL have ports rsp_val (output, 1), rsp_rdy (input, 1), rsp_type (output, 1) and rsp_data (output, p_data_nbits), the response handshake and payload.
REQ-008 SHALL have SRAM-side ports sram_read_en, sram_read_addr, sram_write_en, sram_write_byte_en, sram_write_addr and sram_write_data (outputs), plus sram_read_data (input, p_data_nbits), driving a vc_SynchronousSRAM_1rw.

Function
REQ-009 A request SHALL transfer in any cycle where req_val && req_rdy.
REQ-010 For a read transferred in cycle N, the block SHALL assert sram_read_en with sram_read_addr = req_addr combinationally in cycle N, and SHALL capture sram_read_data in cycle N+1 only.
REQ-011 For a write transferred in cycle N, the block SHALL assert sram_write_en in cycle N, with sram_write_byte_en = req_byte_en, sram_write_addr = req_addr and sram_write_data = req_data.
REQ-012 SRAM enables SHALL be 0 in any cycle with no transfer.
REQ-013 Tracking state SHALL consist of an inflight flag (response due next cycle) and a 2-entry response queue with count 0..2.
REQ-014 req_rdy SHALL equal (count + inflight) < 2 and SHALL NOT depend combinationally on rsp_rdy.
REQ-015 In cycle N+1, if the queue is empty, the due response SHALL appear on rsp_val/rsp_data the same cycle (bypass).
REQ-016 If the bypassed response is not accepted (rsp_rdy = 0), it SHALL be enqueued.
REQ-017 If the queue is non-empty, the due response SHALL be enqueued behind existing entries, and the queue head SHALL drive the response port.
REQ-018 Responses SHALL leave in request order; rsp_type/rsp_data SHALL hold stable while rsp_val && !rsp_rdy.
REQ-019 Simultaneous enqueue and dequeue at count = 2 SHALL NOT occur, because REQ-014 prevents it.
REQ-020 Simultaneous enqueue and dequeue at count = 1 SHALL leave count at 1.
REQ-021 With rsp_rdy held at 1, throughput SHALL be one request per cycle with 1-cycle read latency.
REQ-022 A read to an address written in the immediately preceding transferred cycle SHALL return the new data.

Reset
REQ-023 On reset low, the block SHALL asynchronously clear inflight, count and queue pointers.
REQ-024 During reset, outputs SHALL be: req_rdy = 0, rsp_val = 0, all SRAM enables = 0.
REQ-025 After reset deasserts, req_rdy SHALL be 1 in the next cycle.
REQ-026 Reset mid-operation SHALL discard any in-flight or queued responses; no stale response SHALL appear after reset.
REQ-027 SRAM contents SHALL be unaffected by reset.

Configuration
REQ-028 Macro VC_SRAM_ADAPTER_WRITE_ACK_EN SHALL control write responses.
REQ-029 When VC_SRAM_ADAPTER_WRITE_ACK_EN is defined, each write SHALL occupy the inflight slot and produce a response with rsp_type = 1 and rsp_data = 0, ordered with reads.
REQ-030 When VC_SRAM_ADAPTER_WRITE_ACK_EN is undefined, writes SHALL produce no response, SHALL NOT set inflight, and SHALL NOT count against req_rdy.

Structure
REQ-031 Package vc_sram_adapter_pkg SHALL hold the req_type encoding constants (READ = 0, WRITE = 1) and the response entry struct {type, data}.
REQ-032 Sub-module vc_sram_adapter_rsp_queue SHALL implement the 2-entry response queue (enq_val, deq_rdy, count, head entry), asynchronously reset by reset.
REQ-033 The block SHALL be synthesizable, with no latches.

Verification
REQ-034 Write addr 0 data 'haaaa, byte_en 'b11, then read addr 0 -> rsp_data 'haaaa exactly 1 cycle after the read is accepted.
REQ-035 Write addrs 0..4 with 'haaaa..'heeee, then read 0..4 back-to-back with rsp_rdy = 1 -> one response per cycle, in order, req_rdy never 0.
REQ-036 Issue reads to addrs 1, 2, 3 with rsp_rdy = 0 -> req_rdy = 0 after two reads are accepted; releasing rsp_rdy drains 'hbbbb then 'hcccc, and the third read is then accepted.
REQ-037 Partial writes: byte_en 'b10 data 'haaaa, then 'b01 data 'hdddd, then 'b00 data 'h0123 to addr 0 -> read returns 'haadd.
REQ-038 Assert reset low while two responses are queued -> rsp_val = 0 immediately; after release req_rdy = 1 and no response appears.
REQ-039 With VC_SRAM_ADAPTER_WRITE_ACK_EN, write then read -> two responses: (type 1, data 0) then read data; without the macro -> one response.
